// File: rtl/clk_div_pkg.sv
// Shared defaults, channel action encoding and helpers for the multi-channel clock divider.
package clk_div_pkg;

  localparam int DIV_W_DEF   = 11;
  localparam int DEF_DIV_DEF = 4;

  typedef enum logic [1:0] {
    CH_STOP,
    CH_HOLD,
    CH_RUN,
    CH_SYNC
  } chan_mode_t;

  // Length of the low phase: d - ceil(d/2) == floor(d/2)
  function automatic logic [31:0] half_lo(input logic [31:0] d);
    return d >> 1;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/shadow divisor, tick and divided-clock outputs.
// Optional CLK_DIV_SYNC_EN adds a sync input that restarts the channel.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int DIV_W   = DIV_W_DEF,
  parameter int DEF_DIV = DEF_DIV_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             wr,
  input  logic [DIV_W-1:0] din,
`ifdef CLK_DIV_SYNC_EN
  input  logic             sync,
`endif
  output logic             tick,
  output logic             div_clk,
  output logic             pending
);

  logic [DIV_W-1:0] cnt, d_act, shadow;
  logic [DIV_W-1:0] cnt_nx, d_nx, shadow_nx;
  logic             tick_nx, dclk_nx, pend_nx;

  logic             sync_i;
  logic [DIV_W-1:0] d_new, d_eff, d_ref, cnt_n, h;
  logic             wrap_old, wrap, apply;
  chan_mode_t       mode;

`ifdef CLK_DIV_SYNC_EN
  assign sync_i = sync;
`else
  assign sync_i = 1'b0;
`endif

  // A stopped channel (d_act==0) applies its shadow on any edge; a running one only at wrap.
  always_comb begin
    d_new    = wr ? din : shadow;
    wrap_old = (d_act != '0) && (cnt == d_act - DIV_W'(1));
    apply    = sync_i || (d_act == '0) || (en && wrap_old);
    d_eff    = apply ? d_new : d_act;
    d_ref    = (d_act == '0) ? d_eff : d_act;
    wrap     = (d_ref != '0) && (cnt == d_ref - DIV_W'(1));
    cnt_n    = wrap ? '0 : cnt + DIV_W'(1);
    h        = DIV_W'(half_lo(32'(d_eff)));

    if (sync_i)
      mode = CH_SYNC;
    else if (d_eff == '0)
      mode = CH_STOP;
    else if (en)
      mode = CH_RUN;
    else
      mode = CH_HOLD;
  end

  always_comb begin
    cnt_nx    = cnt;
    d_nx      = d_act;
    shadow_nx = wr ? din : shadow;
    pend_nx   = pending;
    tick_nx   = 1'b0;
    dclk_nx   = div_clk;

    if (apply) begin
      d_nx    = d_new;
      pend_nx = 1'b0;
    end else if (wr) begin
      pend_nx = 1'b1;
    end

    case (mode)
      CH_STOP: begin
        cnt_nx  = '0;
        dclk_nx = 1'b0;
      end
      CH_RUN: begin
        cnt_nx  = cnt_n;
        tick_nx = wrap;
        dclk_nx = (cnt_n >= h);
      end
      CH_SYNC: begin
        cnt_nx  = '0;
        dclk_nx = (d_eff == DIV_W'(1));
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      d_act   <= DIV_W'(DEF_DIV);
      shadow  <= DIV_W'(DEF_DIV);
      pending <= 1'b0;
      tick    <= 1'b0;
      div_clk <= 1'b0;
    end else begin
      cnt     <= cnt_nx;
      d_act   <= d_nx;
      shadow  <= shadow_nx;
      pending <= pend_nx;
      tick    <= tick_nx;
      div_clk <= dclk_nx;
    end
  end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: CH independent clk_div_chan instances.
// Optional CLK_DIV_SYNC_EN adds a sync port that phase-aligns all channels.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int CH      = 2,
  parameter int DIV_W   = DIV_W_DEF,
  parameter int DEF_DIV = DEF_DIV_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [CH-1:0]       div_wr,
  input  logic [CH*DIV_W-1:0] div_in,
`ifdef CLK_DIV_SYNC_EN
  input  logic                sync,
`endif
  output logic [CH-1:0]       tick,
  output logic [CH-1:0]       div_clk,
  output logic [CH-1:0]       pending
);

  for (genvar g = 0; g < CH; g++) begin : g_chan
    clk_div_chan #(
      .DIV_W  (DIV_W),
      .DEF_DIV(DEF_DIV)
    ) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en),
      .wr     (div_wr[g]),
      .din    (div_in[g*DIV_W +: DIV_W]),
`ifdef CLK_DIV_SYNC_EN
      .sync   (sync),
`endif
      .tick   (tick[g]),
      .div_clk(div_clk[g]),
      .pending(pending[g])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi: directed vector table, hand sequences and
// randomized traffic compared against a period/phase model of each channel.
module tb_clk_div_multi;

  localparam int CH    = 2;
  localparam int DIV_W = 11;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                en = 1'b0;
  logic [CH-1:0]       div_wr = '0;
  logic [CH*DIV_W-1:0] div_in = '0;
  logic                sync = 1'b0;
  logic [CH-1:0]       tick, div_clk, pending;

  int checks = 0;
  int errors = 0;

  // Model: phase within period, active/shadow divisor per channel
  int            m_pos [CH];
  int            m_d   [CH];
  int            m_sh  [CH];
  logic [CH-1:0] m_tick, m_clk, m_pend;

  typedef struct {
    logic          en;
    logic [CH-1:0] wr;
    int            wval;
    logic [CH-1:0] tick;
    logic [CH-1:0] dclk;
    logic [CH-1:0] pend;
  } vec_t;

  vec_t tbl [18];

  clk_div_multi #(.CH(CH), .DIV_W(DIV_W), .DEF_DIV(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .div_wr (div_wr),
    .div_in (div_in),
`ifdef CLK_DIV_SYNC_EN
    .sync   (sync),
`endif
    .tick   (tick),
    .div_clk(div_clk),
    .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic modelReset();
    for (int i = 0; i < CH; i++) begin
      m_pos[i] = 0;
      m_d[i]   = 4;
      m_sh[i]  = 4;
    end
    m_tick = '0;
    m_clk  = '0;
    m_pend = '0;
  endtask

  task automatic modelStep(input logic e, input logic [CH-1:0] w,
                           input logic [CH*DIV_W-1:0] di, input logic s);
    for (int i = 0; i < CH; i++) begin
      int val, nd, period;
      bit ap, t;
      val = int'(di[i*DIV_W +: DIV_W]);
      if (s) begin
        nd        = w[i] ? val : m_sh[i];
        m_sh[i]   = nd;
        m_d[i]    = nd;
        m_pend[i] = 1'b0;
        m_pos[i]  = 0;
        m_tick[i] = 1'b0;
        m_clk[i]  = (nd == 1);
      end else begin
        ap = (m_d[i] == 0) || (e && (m_pos[i] == m_d[i] - 1));
        nd = ap ? (w[i] ? val : m_sh[i]) : m_d[i];
        if (w[i]) m_sh[i] = val;
        m_pend[i] = ap ? 1'b0 : (w[i] ? 1'b1 : m_pend[i]);
        if (nd == 0) begin
          m_pos[i]  = 0;
          m_tick[i] = 1'b0;
          m_clk[i]  = 1'b0;
        end else if (e) begin
          period    = (m_d[i] != 0) ? m_d[i] : nd;
          t         = (m_pos[i] + 1 == period);
          m_pos[i]  = t ? 0 : m_pos[i] + 1;
          m_tick[i] = t;
          m_clk[i]  = (m_pos[i] >= nd / 2);
        end else begin
          m_tick[i] = 1'b0;
        end
        m_d[i] = nd;
      end
    end
  endtask

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    for (int i = 0; i < CH; i++) begin
      check($sformatf("model tick[%0d]", i), tick[i], m_tick[i]);
      check($sformatf("model div_clk[%0d]", i), div_clk[i], m_clk[i]);
      check($sformatf("model pending[%0d]", i), pending[i], m_pend[i]);
    end
  endtask

  // Called at a negedge: drive inputs, step model at posedge+1, compare, return at next negedge
  task automatic applyStimulus(input logic e, input logic [CH-1:0] w,
                               input logic [CH*DIV_W-1:0] di, input logic s);
    en     = e;
    div_wr = w;
    div_in = di;
    sync   = s;
    @(posedge clk);
    #1;
    modelStep(e, w, di, s);
    checkOutput();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b1, '0, '0, 1'b0);
  endtask

  function automatic logic [CH*DIV_W-1:0] packDiv(input int ch, input int val);
    logic [CH*DIV_W-1:0] v;
    v = '0;
    v[ch*DIV_W +: DIV_W] = DIV_W'(val);
    return v;
  endfunction

  initial begin
    modelReset();

    tbl[0]  = '{1'b1, 2'b00, 0, 2'b00, 2'b00, 2'b00};
    tbl[1]  = '{1'b1, 2'b00, 0, 2'b00, 2'b11, 2'b00};
    tbl[2]  = '{1'b1, 2'b00, 0, 2'b00, 2'b11, 2'b00};
    tbl[3]  = '{1'b1, 2'b00, 0, 2'b11, 2'b00, 2'b00};
    tbl[4]  = '{1'b1, 2'b00, 0, 2'b00, 2'b00, 2'b00};
    tbl[5]  = '{1'b1, 2'b01, 5, 2'b00, 2'b11, 2'b01};
    tbl[6]  = '{1'b1, 2'b00, 0, 2'b00, 2'b11, 2'b01};
    tbl[7]  = '{1'b1, 2'b00, 0, 2'b11, 2'b00, 2'b00};
    tbl[8]  = '{1'b1, 2'b00, 0, 2'b00, 2'b00, 2'b00};
    tbl[9]  = '{1'b1, 2'b00, 0, 2'b00, 2'b11, 2'b00};
    tbl[10] = '{1'b1, 2'b00, 0, 2'b00, 2'b11, 2'b00};
    tbl[11] = '{1'b1, 2'b00, 0, 2'b10, 2'b01, 2'b00};
    tbl[12] = '{1'b1, 2'b00, 0, 2'b01, 2'b00, 2'b00};
    tbl[13] = '{1'b1, 2'b00, 0, 2'b00, 2'b10, 2'b00};
    tbl[14] = '{1'b1, 2'b00, 0, 2'b00, 2'b11, 2'b00};
    tbl[15] = '{1'b1, 2'b00, 0, 2'b10, 2'b01, 2'b00};
    tbl[16] = '{1'b1, 2'b00, 0, 2'b00, 2'b01, 2'b00};
    tbl[17] = '{1'b1, 2'b00, 0, 2'b01, 2'b10, 2'b00};

    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < CH; i++) begin
      check("reset tick", tick[i], 1'b0);
      check("reset div_clk", div_clk[i], 1'b0);
      check("reset pending", pending[i], 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Default divisor 4 on both channels, then ch0 reprogrammed to 5 mid-period
    for (int v = 0; v < 18; v++) begin
      applyStimulus(tbl[v].en, tbl[v].wr, packDiv(0, tbl[v].wval), 1'b0);
      for (int i = 0; i < CH; i++) begin
        check($sformatf("vec%0d tick[%0d]", v + 1, i), tick[i], tbl[v].tick[i]);
        check($sformatf("vec%0d div_clk[%0d]", v + 1, i), div_clk[i], tbl[v].dclk[i]);
        check($sformatf("vec%0d pending[%0d]", v + 1, i), pending[i], tbl[v].pend[i]);
      end
    end

    // d=1 on ch0: applied at its next wrap, then tick and div_clk stay high
    applyStimulus(1'b1, 2'b01, packDiv(0, 1), 1'b0);
    for (int k = 0; k < 20 && m_pend[0]; k++) idle(1);
    check("d1 apply timeout", m_pend[0], 1'b0);
    for (int k = 0; k < 4; k++) begin
      idle(1);
      check("d1 tick", tick[0], 1'b1);
      check("d1 div_clk", div_clk[0], 1'b1);
    end
    applyStimulus(1'b1, 2'b01, packDiv(0, 0), 1'b0);
    for (int k = 0; k < 3; k++) begin
      check("d0 tick", tick[0], 1'b0);
      check("d0 div_clk", div_clk[0], 1'b0);
      idle(1);
    end
    applyStimulus(1'b1, 2'b01, packDiv(0, 3), 1'b0);
    check("stopped write pending", pending[0], 1'b0);
    idle(7);

    // en low for 7 cycles: no ticks, divided clocks frozen
    begin
      logic [CH-1:0] frozen;
      frozen = m_clk;
      for (int k = 0; k < 7; k++) begin
        applyStimulus(1'b0, '0, '0, 1'b0);
        check("en0 tick0", tick[0], 1'b0);
        check("en0 tick1", tick[1], 1'b0);
        check("en0 div_clk0", div_clk[0], frozen[0]);
        check("en0 div_clk1", div_clk[1], frozen[1]);
      end
    end
    idle(8);

    // Write coincident with ch1 wrap: 4 -> 6 applied immediately, next tick 6 later
    for (int k = 0; k < 10 && (m_d[1] == 0 || m_pos[1] != m_d[1] - 1); k++) idle(1);
    check("wrap align timeout", (m_pos[1] == m_d[1] - 1), 1'b1);
    applyStimulus(1'b1, 2'b10, packDiv(1, 6), 1'b0);
    check("coincident tick", tick[1], 1'b1);
    check("coincident pending", pending[1], 1'b0);
    for (int k = 0; k < 6; k++) begin
      idle(1);
      check("d6 pending", pending[1], 1'b0);
      check("d6 tick", tick[1], (k == 5));
    end

    // Asynchronous reset mid-period
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < CH; i++) begin
      check("async rst tick", tick[i], 1'b0);
      check("async rst div_clk", div_clk[i], 1'b0);
      check("async rst pending", pending[i], 1'b0);
    end
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(5);

`ifdef CLK_DIV_SYNC_EN
    applyStimulus(1'b1, 2'b11, packDiv(0, 3) | packDiv(1, 6), 1'b0);
    applyStimulus(1'b1, '0, '0, 1'b1);
    check("sync tick", tick[0] | tick[1], 1'b0);
    for (int k = 0; k < 12; k++) begin
      idle(1);
      if (k % 6 == 5) begin
        check("sync common tick0", tick[0], 1'b1);
        check("sync common tick1", tick[1], 1'b1);
      end
    end
`endif

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      logic                e, s;
      logic [CH-1:0]       w;
      logic [CH*DIV_W-1:0] di;
      e  = ($urandom_range(0, 7) != 0);
      di = '0;
      for (int i = 0; i < CH; i++) begin
        w[i] = ($urandom_range(0, 9) == 0);
        di[i*DIV_W +: DIV_W] = DIV_W'($urandom_range(0, 9));
      end
`ifdef CLK_DIV_SYNC_EN
      s = ($urandom_range(0, 39) == 0);
`else
      s = 1'b0;
`endif
      applyStimulus(e, w, di, s);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
